axi_ram_responder: RTL and testbench

AXI_RAM_RESPONDER -- requirements
Module: axi_ram_responder

---
 rtl/axi_ram_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a MEM_SIZE-byte RAM; one transaction in flight, zero-cleared after reset.
// Define AXI_RAM_RESPONDER_WRAP_EN to accept WRAP bursts; without it WRAP answers SLVERR.
module axi_ram_responder #(
  parameter int unsigned ID_WIDTH = 6,
  parameter int unsigned MEM_SIZE = 32'h10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] i_awid,
  input  logic [31:0]         i_awaddr,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [63:0]         i_wdata,
  input  logic [7:0]          i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [ID_WIDTH-1:0] o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [ID_WIDTH-1:0] i_arid,
  input  logic [31:0]         i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [ID_WIDTH-1:0] o_rid,
  output logic [63:0]         o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic                o_init_done,
  output logic                o_init_error
);
  localparam int unsigned AW    = $clog2(MEM_SIZE);
  localparam int unsigned IW    = AW - 3;
  localparam int unsigned WORDS = MEM_SIZE / 8;
  localparam logic [IW:0] CLR_ONE = {{IW{1'b0}}, 1'b1};
`ifdef AXI_RAM_RESPONDER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {CLEAR, IDLE, WDATA, WRESP, RDATA} state_e;

  state_e              state_q;
  logic [IW:0]         clr_idx_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q, beat_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q, wlast_err_q, init_done_q;
  logic                bvalid_q, rvalid_q, rlast_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [ID_WIDTH-1:0] bid_q, rid_q;
  logic [63:0]         rdata_q;
  logic [63:0]         mem [WORDS];

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    burst_err = (size > 3'd3) || (burst == 2'b11) ||
                ((burst == 2'b10) && (!WRAP_EN || !wrap_len_ok));
  endfunction

  // WRAP keeps the bits above the (len+1)<<size window and wraps the increment inside it.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
    logic [31:0] inc, mask;
    inc  = a + (32'd1 << size);
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    if (burst == 2'b00)                     next_addr = a;
    else if (WRAP_EN && (burst == 2'b10))   next_addr = (a & ~mask) | (inc & mask);
    else                                    next_addr = inc;
  endfunction

  logic aw_hs, ar_hs, w_hs, w_last_beat, ar_err;
  assign aw_hs       = (state_q == IDLE) && i_awvalid;
  assign ar_hs       = (state_q == IDLE) && i_arvalid && !i_awvalid;
  assign w_hs        = (state_q == WDATA) && i_wvalid;
  assign w_last_beat = (beat_q == len_q);
  assign ar_err      = burst_err(i_arsize, i_arburst, i_arlen);

  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdat;

  // Single RAM port: clear sweep, write beats and read beats never overlap in time.
  always_comb begin
    mem_we   = 1'b0;
    mem_be   = 8'hFF;
    mem_wdat = 64'd0;
    mem_idx  = addr_q[AW-1:3];
    case (state_q)
      CLEAR: begin
        mem_we  = !clr_idx_q[IW];
        mem_idx = clr_idx_q[IW-1:0];
      end
      IDLE:  mem_idx = i_araddr[AW-1:3];
      WDATA: begin
        mem_we   = w_hs && !err_q;
        mem_be   = i_wstrb;
        mem_wdat = i_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
      init_done_q <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      bresp_q     <= '0;
      rresp_q     <= '0;
      bid_q       <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_idx_q[IW]) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + CLR_ONE;
          end
        end
        IDLE: begin
          if (aw_hs) begin
            bid_q       <= i_awid;
            addr_q      <= i_awaddr;
            len_q       <= i_awlen;
            size_q      <= i_awsize;
            burst_q     <= i_awburst;
            err_q       <= burst_err(i_awsize, i_awburst, i_awlen);
            wlast_err_q <= 1'b0;
            beat_q      <= '0;
            state_q     <= WDATA;
          end else if (ar_hs) begin
            // addr_q tracks the next beat to fetch; beat 0 is read right now.
            rid_q    <= i_arid;
            len_q    <= i_arlen;
            size_q   <= i_arsize;
            burst_q  <= i_arburst;
            err_q    <= ar_err;
            addr_q   <= next_addr(i_araddr, i_arsize, i_arburst, i_arlen);
            beat_q   <= '0;
            rvalid_q <= 1'b1;
            rlast_q  <= (i_arlen == 8'd0);
            rresp_q  <= ar_err ? 2'b10 : 2'b00;
            rdata_q  <= ar_err ? 64'd0 : mem[mem_idx];
            state_q  <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            if (w_last_beat) begin
              state_q  <= WRESP;
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || wlast_err_q || !i_wlast) ? 2'b10 : 2'b00;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= next_addr(addr_q, size_q, burst_q, len_q);
              if (i_wlast) wlast_err_q <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (i_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RDATA: begin
          if (i_rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              rlast_q <= ((beat_q + 8'd1) == len_q);
              addr_q  <= next_addr(addr_q, size_q, burst_q, len_q);
              rdata_q <= err_q ? 64'd0 : mem[mem_idx];
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign o_awready    = (state_q == IDLE);
  assign o_arready    = (state_q == IDLE) && !i_awvalid;
  assign o_wready     = (state_q == WDATA);
  assign o_bid        = bid_q;
  assign o_bresp      = bresp_q;
  assign o_bvalid     = bvalid_q;
  assign o_rid        = rid_q;
  assign o_rdata      = rdata_q;
  assign o_rresp      = rresp_q;
  assign o_rlast      = rlast_q;
  assign o_rvalid     = rvalid_q;
  assign o_init_done  = init_done_q;
  assign o_init_error = 1'b0;
endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder (1 KiB memory): clear timing, INCR/stall reads, arbitration, errors, WRAP.
module tb_axi_ram_responder;
  localparam int MEM   = 1024;
  localparam int WORDS = MEM / 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  i_awid, i_arid, o_bid, o_rid;
  logic [31:0] i_awaddr, i_araddr;
  logic [7:0]  i_awlen, i_arlen, i_wstrb;
  logic [2:0]  i_awsize, i_arsize;
  logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
  logic        i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
  logic        i_arvalid, o_arready, o_rlast, o_rvalid, i_rready, o_init_done, o_init_error;
  logic [63:0] i_wdata, o_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] wdat  [16];
  logic [63:0] exp_d [16];
  logic [1:0]  resp;

  axi_ram_responder #(.ID_WIDTH(6), .MEM_SIZE(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
    .i_rready(i_rready), .o_init_done(o_init_done), .o_init_error(o_init_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic reset_and_clear(input string tag);
    int cnt;
    rst_n = 1'b0;
    #1;
    check({tag, "_initd"}, 64'(o_init_done), 0);
    check({tag, "_rvld"},  64'(o_rvalid), 0);
    check({tag, "_bvld"},  64'(o_bvalid), 0);
    check({tag, "_wrdy"},  64'(o_wready), 0);
    check({tag, "_rdata"}, o_rdata, 0);
    check({tag, "_ierr"},  64'(o_init_error), 0);
    repeat (3) @(posedge clk);
    #1;
    i_awvalid = 1'b1;
    i_arvalid = 1'b1;
    rst_n = 1'b1;
    cnt = 0;
    while (!o_init_done && cnt < 2000) begin
      if (cnt == 5) begin
        check({tag, "_clr_awrdy"}, 64'(o_awready), 0);
        check({tag, "_clr_arrdy"}, 64'(o_arready), 0);
        i_awvalid = 1'b0;
        i_arvalid = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_init_cycles"}, 64'(cnt), 64'(WORDS + 1));
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    i_arid = id; i_araddr = a; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    #1;
    t = 0;
    while (!o_arready && t < 100) begin @(posedge clk); #1; t++; end
    check("ar_rdy", 64'(o_arready), 1);
    @(posedge clk); #1;
    i_arvalid = 1'b0;
    check("r_vld_1cyc", 64'(o_rvalid), 1);
  endtask

  task automatic rd(input string tag, input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                    input logic [1:0] exp_resp);
    int b, t;
    bit ph;
    i_rready = 1'b0;
    ar_send(id, a, len, size, burst);
    b = 0; t = 0; ph = 1'b0;
    while (b <= int'(len) && t < 500) begin
      i_rready = toggle ? ph : 1'b1;
      ph = ~ph;
      #1;
      if (o_rvalid) begin
        check({tag, "_data"}, o_rdata, exp_d[b]);
        if (i_rready) begin
          check({tag, "_resp"}, 64'(o_rresp), 64'(exp_resp));
          check({tag, "_last"}, 64'(o_rlast), 64'(b == int'(len)));
          check({tag, "_id"},   64'(o_rid), 64'(id));
          b++;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    i_rready = 1'b0;
    check({tag, "_beats"}, 64'(b), 64'(int'(len) + 1));
    check({tag, "_vld_end"}, 64'(o_rvalid), 0);
  endtask

  task automatic wr(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                    output logic [1:0] bresp);
    int t;
    i_awid = id; i_awaddr = a; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    #1;
    t = 0;
    while (!o_awready && t < 100) begin @(posedge clk); #1; t++; end
    check("aw_rdy", 64'(o_awready), 1);
    @(posedge clk); #1;
    i_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      i_wdata = wdat[b];
      i_wstrb = 8'hFF;
      i_wlast = (b == int'(len)) ^ (b == bad_last);
      i_wvalid = 1'b1;
      #1;
      t = 0;
      while (!o_wready && t < 100) begin @(posedge clk); #1; t++; end
      check("w_rdy", 64'(o_wready), 1);
      @(posedge clk); #1;
    end
    i_wvalid = 1'b0;
    i_wlast = 1'b0;
    check("b_vld_next", 64'(o_bvalid), 1);
    i_bready = 1'b1;
    #1;
    bresp = o_bresp;
    check("b_id", 64'(o_bid), 64'(id));
    @(posedge clk); #1;
    i_bready = 1'b0;
  endtask

  initial begin
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
    i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
    i_rready = 1'b0;

    reset_and_clear("por");
    exp_d[0] = 64'd0;
    rd("r_zero", 6'd1, 32'h0, 8'd0, 3'd3, 2'b01, 1'b0, 2'b00);

    wdat[0] = 64'h1111_1111_1111_1111; wdat[1] = 64'h2222_2222_2222_2222;
    wdat[2] = 64'h3333_3333_3333_3333; wdat[3] = 64'h4444_4444_4444_4444;
    wr(6'h05, 32'h100, 8'd3, 3'd3, 2'b01, -1, resp);
    check("wr_incr_resp", 64'(resp), 0);
    for (int i = 0; i < 4; i++) exp_d[i] = wdat[i];
    rd("r_incr", 6'h09, 32'h100, 8'd3, 3'd3, 2'b01, 1'b0, 2'b00);

    for (int i = 0; i < 8; i++) wdat[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    wr(6'h02, 32'h200, 8'd7, 3'd3, 2'b01, -1, resp);
    check("wr_len7_resp", 64'(resp), 0);
    for (int i = 0; i < 8; i++) exp_d[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    rd("r_stall", 6'h03, 32'h200, 8'd7, 3'd3, 2'b01, 1'b1, 2'b00);

    wdat[0] = 64'hCAFE_F00D_0000_0300;
    i_arid = 6'd7; i_araddr = 32'h300; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'b01;
    i_arvalid = 1'b1;
    i_awaddr = 32'h300; i_awvalid = 1'b1;
    #1;
    check("both_arrdy", 64'(o_arready), 0);
    check("both_awrdy", 64'(o_awready), 1);
    wr(6'h04, 32'h300, 8'd0, 3'd3, 2'b01, -1, resp);
    check("both_wr_resp", 64'(resp), 0);
    exp_d[0] = 64'hCAFE_F00D_0000_0300;
    rd("r_after_w", 6'd7, 32'h300, 8'd0, 3'd3, 2'b01, 1'b0, 2'b00);

    wdat[0] = 64'hAAAA_AAAA_AAAA_AAAA; wdat[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wr(6'h01, 32'h340, 8'd1, 3'd3, 2'b01, 0, resp);
    check("wlast_early", 64'(resp), 2);
    wr(6'h01, 32'h350, 8'd1, 3'd3, 2'b01, 1, resp);
    check("wlast_missing", 64'(resp), 2);
    wdat[0] = 64'hDEAD_DEAD_DEAD_DEAD;
    wr(6'h01, 32'h100, 8'd0, 3'd4, 2'b01, -1, resp);
    check("wr_size4_resp", 64'(resp), 2);
    exp_d[0] = 64'h1111_1111_1111_1111;
    rd("r_unchanged", 6'd1, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0, 2'b00);
    exp_d[0] = 64'd0; exp_d[1] = 64'd0;
    rd("r_size4", 6'd2, 32'h100, 8'd1, 3'd4, 2'b01, 1'b0, 2'b10);
    rd("r_burst3", 6'd2, 32'h100, 8'd0, 3'd3, 2'b11, 1'b0, 2'b10);

    wdat[0] = 64'hA0A0_A0A0_A0A0_A0A0; wdat[1] = 64'hA1A1_A1A1_A1A1_A1A1;
    wdat[2] = 64'hA2A2_A2A2_A2A2_A2A2; wdat[3] = 64'hA3A3_A3A3_A3A3_A3A3;
    wr(6'h03, 32'h118, 8'd3, 3'd3, 2'b10, -1, resp);
`ifdef AXI_RAM_RESPONDER_WRAP_EN
    check("wrap_resp", 64'(resp), 0);
    exp_d[0] = 64'hA1A1_A1A1_A1A1_A1A1; exp_d[1] = 64'hA2A2_A2A2_A2A2_A2A2;
    exp_d[2] = 64'hA3A3_A3A3_A3A3_A3A3; exp_d[3] = 64'hA0A0_A0A0_A0A0_A0A0;
`else
    check("wrap_resp", 64'(resp), 2);
    exp_d[0] = 64'h1111_1111_1111_1111; exp_d[1] = 64'h2222_2222_2222_2222;
    exp_d[2] = 64'h3333_3333_3333_3333; exp_d[3] = 64'h4444_4444_4444_4444;
`endif
    rd("r_wrap", 6'h03, 32'h100, 8'd3, 3'd3, 2'b01, 1'b0, 2'b00);

    ar_send(6'd1, 32'h200, 8'd7, 3'd3, 2'b01);
    i_rready = 1'b1;
    @(posedge clk); #1;
    i_rready = 1'b0;
    check("mid_rvld", 64'(o_rvalid), 1);
    reset_and_clear("mid");
    exp_d[0] = 64'd0;
    rd("r_recleared", 6'd1, 32'h200, 8'd0, 3'd3, 2'b01, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
